// File: rtl/bulls_cows_judge.sv
// Bulls-and-cows judge: latches a secret, scores guesses one digit per cycle, tracks attempts and win/lose.
// Optional BULLS_COWS_DUP_CHECK_EN rejects secrets and guesses that contain a repeated digit.
module bulls_cows_judge #(
  parameter int MAX_ATTEMPTS = 10,
  parameter int ATTEMPT_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [15:0]          secret_i,
  input  logic                 secret_legal_i,
  input  logic                 secret_load_i,
  input  logic [15:0]          guess_i,
  input  logic                 guess_legal_i,
  input  logic                 guess_valid_i,
  output logic                 armed_o,
  output logic                 busy_o,
  output logic                 result_valid_o,
  output logic [2:0]           bulls_o,
  output logic [2:0]           cows_o,
  output logic [ATTEMPT_W-1:0] attempts_o,
  output logic                 win_o,
  output logic                 lose_o,
  output logic                 guess_err_o
);

  // state | meaning
  // IDLE  | no secret held
  // ARMED | secret held, waiting for a guess
  // SCORE | comparing guess digit idx_q against the secret
  // WIN   | last guess scored four bulls
  // LOSE  | attempts exhausted without a win
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_SCORE = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  localparam logic [ATTEMPT_W-1:0] MAX_ATT = ATTEMPT_W'(MAX_ATTEMPTS);

  logic [2:0]           state_q, state_d;
  logic [15:0]          secret_q, secret_d;
  logic [15:0]          guess_q, guess_d;
  logic [1:0]           idx_q, idx_d;
  logic [2:0]           scr_bulls_q, scr_bulls_d;
  logic [2:0]           scr_cows_q, scr_cows_d;
  logic [2:0]           bulls_q, bulls_d;
  logic [2:0]           cows_q, cows_d;
  logic [ATTEMPT_W-1:0] attempts_q, attempts_d;
  logic                 result_valid_q, result_valid_d;
  logic                 guess_err_q, guess_err_d;

  logic [3:0]           g_dig;
  logic [3:0]           s_dig;
  logic                 is_bull;
  logic                 in_other;
  logic                 is_cow;
  logic [2:0]           bulls_sum;
  logic [2:0]           cows_sum;
  logic [ATTEMPT_W-1:0] att_next;

  function automatic logic [3:0] digit_at(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] d;
    case (i)
      2'd0:    d = v[15:12];
      2'd1:    d = v[11:8];
      2'd2:    d = v[7:4];
      default: d = v[3:0];
    endcase
    return d;
  endfunction

  function automatic logic digits_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
           (v[7:4]   <= 4'd9) && (v[3:0]  <= 4'd9);
  endfunction

`ifdef BULLS_COWS_DUP_CHECK_EN
  function automatic logic no_dups(input logic [15:0] v);
    return (v[15:12] != v[11:8]) && (v[15:12] != v[7:4]) && (v[15:12] != v[3:0]) &&
           (v[11:8]  != v[7:4])  && (v[11:8]  != v[3:0]) && (v[7:4]   != v[3:0]);
  endfunction

  function automatic logic word_ok(input logic [15:0] v);
    return digits_ok(v) && no_dups(v);
  endfunction
`else
  function automatic logic word_ok(input logic [15:0] v);
    return digits_ok(v);
  endfunction
`endif

  // Per-digit compare for the current index; a cow only counts when the digit is not a bull.
  always_comb begin
    g_dig    = digit_at(guess_q, idx_q);
    s_dig    = digit_at(secret_q, idx_q);
    is_bull  = (g_dig == s_dig);
    in_other = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) != idx_q) && (digit_at(secret_q, 2'(j)) == g_dig)) begin
        in_other = 1'b1;
      end
    end
    is_cow    = !is_bull && in_other;
    bulls_sum = scr_bulls_q + {2'b00, is_bull};
    cows_sum  = scr_cows_q + {2'b00, is_cow};
    att_next  = (attempts_q == MAX_ATT) ? attempts_q : attempts_q + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    secret_d       = secret_q;
    guess_d        = guess_q;
    idx_d          = idx_q;
    scr_bulls_d    = scr_bulls_q;
    scr_cows_d     = scr_cows_q;
    bulls_d        = bulls_q;
    cows_d         = cows_q;
    attempts_d     = attempts_q;
    result_valid_d = 1'b0;
    guess_err_d    = 1'b0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (secret_load_i && secret_legal_i && word_ok(secret_i)) begin
          secret_d   = secret_i;
          attempts_d = '0;
          bulls_d    = 3'd0;
          cows_d     = 3'd0;
          state_d    = S_ARMED;
        end
      end
      S_ARMED: begin
        if (guess_valid_i) begin
          if (guess_legal_i && word_ok(guess_i)) begin
            guess_d     = guess_i;
            scr_bulls_d = 3'd0;
            scr_cows_d  = 3'd0;
            idx_d       = 2'd0;
            state_d     = S_SCORE;
          end else begin
            guess_err_d = 1'b1;
          end
        end
      end
      S_SCORE: begin
        if (idx_q == 2'd3) begin
          bulls_d        = bulls_sum;
          cows_d         = cows_sum;
          result_valid_d = 1'b1;
          attempts_d     = att_next;
          idx_d          = 2'd0;
          // A four-bull finish wins even when it was also the last allowed attempt.
          if (bulls_sum == 3'd4) begin
            state_d = S_WIN;
          end else if (att_next == MAX_ATT) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          scr_bulls_d = bulls_sum;
          scr_cows_d  = cows_sum;
          idx_d       = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      secret_q       <= '0;
      guess_q        <= '0;
      idx_q          <= 2'd0;
      scr_bulls_q    <= 3'd0;
      scr_cows_q     <= 3'd0;
      bulls_q        <= 3'd0;
      cows_q         <= 3'd0;
      attempts_q     <= '0;
      result_valid_q <= 1'b0;
      guess_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      guess_q        <= guess_d;
      idx_q          <= idx_d;
      scr_bulls_q    <= scr_bulls_d;
      scr_cows_q     <= scr_cows_d;
      bulls_q        <= bulls_d;
      cows_q         <= cows_d;
      attempts_q     <= attempts_d;
      result_valid_q <= result_valid_d;
      guess_err_q    <= guess_err_d;
    end
  end

  assign armed_o        = (state_q == S_ARMED);
  assign busy_o         = (state_q == S_SCORE);
  assign win_o          = (state_q == S_WIN);
  assign lose_o         = (state_q == S_LOSE);
  assign result_valid_o = result_valid_q;
  assign guess_err_o    = guess_err_q;
  assign bulls_o        = bulls_q;
  assign cows_o         = cows_q;
  assign attempts_o     = attempts_q;

endmodule

// File: tb/tb_bulls_cows_judge.sv
// Directed plus randomized bench for bulls_cows_judge against a digit-array reference model.
// Expectations follow BULLS_COWS_DUP_CHECK_EN when it is defined.
module tb_bulls_cows_judge;

  localparam int MAX_ATT = 10;
  localparam int AW      = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_WIN   = 2;
  localparam int M_LOSE  = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [15:0]   secret_i = '0;
  logic          secret_legal_i = 1'b0;
  logic          secret_load_i = 1'b0;
  logic [15:0]   guess_i = '0;
  logic          guess_legal_i = 1'b0;
  logic          guess_valid_i = 1'b0;
  logic          armed_o, busy_o, result_valid_o, win_o, lose_o, guess_err_o;
  logic [2:0]    bulls_o, cows_o;
  logic [AW-1:0] attempts_o;

  int n_checks = 0;
  int n_errs   = 0;

  int m_st, m_att, m_bulls, m_cows;
  logic [15:0] m_secret;

  bulls_cows_judge #(.MAX_ATTEMPTS(MAX_ATT), .ATTEMPT_W(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .secret_i(secret_i), .secret_legal_i(secret_legal_i), .secret_load_i(secret_load_i),
    .guess_i(guess_i), .guess_legal_i(guess_legal_i), .guess_valid_i(guess_valid_i),
    .armed_o(armed_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .bulls_o(bulls_o), .cows_o(cows_o), .attempts_o(attempts_o),
    .win_o(win_o), .lose_o(lose_o), .guess_err_o(guess_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errs++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int dig(input logic [15:0] v, input int i);
    return int'((v >> (12 - 4 * i)) & 16'hF);
  endfunction

  function automatic bit ref_legal(input logic [15:0] v, input bit flag);
    if (!flag) return 1'b0;
    for (int i = 0; i < 4; i++) if (dig(v, i) > 9) return 1'b0;
`ifdef BULLS_COWS_DUP_CHECK_EN
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (dig(v, i) == dig(v, j)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic ref_score(input logic [15:0] s, input logic [15:0] g, output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (dig(g, i) == dig(s, i)) b++;
      else begin
        bit found = 1'b0;
        for (int j = 0; j < 4; j++) if (j != i && dig(g, i) == dig(s, j)) found = 1'b1;
        if (found) c++;
      end
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".armed"},    armed_o,    (m_st == M_ARMED));
    chk({tag, ".busy"},     busy_o,     0);
    chk({tag, ".win"},      win_o,      (m_st == M_WIN));
    chk({tag, ".lose"},     lose_o,     (m_st == M_LOSE));
    chk({tag, ".attempts"}, attempts_o, m_att);
    chk({tag, ".bulls"},    bulls_o,    m_bulls);
    chk({tag, ".cows"},     cows_o,     m_cows);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_att = 0; m_bulls = 0; m_cows = 0; m_secret = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rv"},  result_valid_o, 0);
    chk({tag, ".err"}, guess_err_o, 0);
    check_status(tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    model_reset();
    check_all_zero("reset");
  endtask

  task automatic do_load(input logic [15:0] s, input bit legal, input bit with_guess);
    secret_i = s; secret_legal_i = legal; secret_load_i = 1'b1;
    guess_i = s; guess_legal_i = 1'b1; guess_valid_i = with_guess;
    step();
    secret_load_i = 1'b0; guess_valid_i = 1'b0;
    if (m_st != M_ARMED && ref_legal(s, legal)) begin
      m_st = M_ARMED; m_att = 0; m_bulls = 0; m_cows = 0; m_secret = s;
    end
    check_status("load");
    chk("load.err", guess_err_o, 0);
    if (with_guess) begin
      step();
      chk("load_guess.busy", busy_o, 0);
      chk("load_guess.rv", result_valid_o, 0);
    end
  endtask

  task automatic do_guess(input logic [15:0] g, input bit legal);
    int b, c;
    guess_i = g; guess_legal_i = legal; guess_valid_i = 1'b1;
    step();
    guess_valid_i = 1'b0;
    if (m_st == M_ARMED && ref_legal(g, legal)) begin
      ref_score(m_secret, g, b, c);
      chk("score.busy0", busy_o, 1);
      chk("score.rv0", result_valid_o, 0);
      repeat (3) begin
        step();
        chk("score.busy", busy_o, 1);
      end
      step();
      chk("score.rv", result_valid_o, 1);
      m_bulls = b; m_cows = c;
      if (m_att < MAX_ATT) m_att++;
      if (b == 4) m_st = M_WIN;
      else if (m_att == MAX_ATT) m_st = M_LOSE;
      else m_st = M_ARMED;
      check_status("score");
      step();
      chk("score.rv_end", result_valid_o, 0);
    end else if (m_st == M_ARMED) begin
      chk("reject.err", guess_err_o, 1);
      check_status("reject");
      step();
      chk("reject.err_end", guess_err_o, 0);
    end else begin
      chk("ignore.err", guess_err_o, 0);
      chk("ignore.busy", busy_o, 0);
      repeat (4) step();
      chk("ignore.rv", result_valid_o, 0);
      check_status("ignore");
    end
  endtask

  initial begin
    logic [15:0] rs;
    logic [15:0] rg;
    int perm[10];
    model_reset();

    rst_i = 1'b1;
    step();
    do_reset();

    do_load(16'h1234, 1'b1, 1'b0);
    do_guess(16'h1243, 1'b1);
    do_guess(16'h12F4, 1'b1);
    do_guess(16'h1234, 1'b0);
    do_guess(16'h1123, 1'b1);

    // Random secret with distinct digits so it loads in either build.
    do_reset();
    for (int i = 0; i < 10; i++) perm[i] = i;
    for (int i = 9; i > 0; i--) begin
      int k, t;
      k = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[k]; perm[k] = t;
    end
    rs = {perm[0][3:0], perm[1][3:0], perm[2][3:0], perm[3][3:0]};
    do_load(rs, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      rg = '0;
      for (int i = 0; i < 4; i++) begin
        int d;
        d = ($urandom_range(0, 11) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        if ($urandom_range(0, 2) == 0) d = dig(rs, int'($urandom_range(0, 3)));
        rg = {rg[11:0], 4'(d)};
      end
      do_guess(rg, $urandom_range(0, 7) != 0);
    end

    do_reset();
    do_load(16'h1234, 1'b1, 1'b0);
    do_guess(16'h1234, 1'b1);
    do_guess(16'h1234, 1'b1);
    do_load(16'h12A4, 1'b1, 1'b0);
    do_load(16'h5678, 1'b0, 1'b0);
    do_load(16'h1234, 1'b1, 1'b0);
    for (int n = 0; n < MAX_ATT; n++) do_guess(16'h5678, 1'b1);
    do_guess(16'h1234, 1'b1);
    do_load(16'h9876, 1'b1, 1'b0);
    do_load(16'h4321, 1'b1, 1'b0);
    do_guess(16'h9876, 1'b1);
    do_load(16'h1234, 1'b1, 1'b1);

    // Reset during the second scoring cycle discards the compare.
    guess_i = 16'h1243; guess_legal_i = 1'b1; guess_valid_i = 1'b1;
    step();
    guess_valid_i = 1'b0;
    chk("midrst.busy_pre", busy_o, 1);
    step();
    do_reset();
    repeat (4) step();
    chk("midrst.rv", result_valid_o, 0);
    check_status("midrst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bulls_cows_judge.md
Name: bulls_cows_judge

Overview:
Downstream consumer of the 4-digit entry stage. It latches a legal 16-bit secret, then scores each legal 16-bit guess into bulls and cows over a fixed 4-cycle sequential compare. It counts attempts and declares win or lose. Its outputs drive the score display and game-status LEDs.

Parameters:
MAX_ATTEMPTS, 10, guesses allowed before lose (1..2^ATTEMPT_W-1)
ATTEMPT_W, 4, width of attempt counter

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
secret  input  16  secret digits, BCD nibbles, digit0 = [15:12] ... digit3 = [3:0]
secret_legal  input  1  entry stage reports all four secret nibbles filled
secret_load  input  1  one-cycle request to latch secret
guess  input  16  guess digits, same nibble order
guess_legal  input  1  entry stage reports all four guess nibbles filled
guess_valid  input  1  one-cycle request to score guess
armed  output  1  secret held; guesses accepted
busy  output  1  scoring in progress
result_valid  output  1  one-cycle pulse: bulls/cows updated
bulls  output  3  0..4
cows  output  3  0..4
attempts  output  ATTEMPT_W  scored guesses since last secret load
win  output  1  level; set on bulls==4
lose  output  1  level; set when attempts reach MAX_ATTEMPTS without win
guess_err  output  1  one-cycle pulse: guess rejected

Behaviour:
- Reset (rst high at a CLK edge), also mid-scoring: state IDLE. All outputs are 0, secret register is 0, digit index is 0. An in-flight score is discarded.
- States: IDLE, ARMED, SCORE, WIN, LOSE.
- Secret load:
  - Accepted only in IDLE, WIN or LOSE, when secret_load=1, secret_legal=1 and every nibble is <=9.
  - On acceptance: latch secret, attempts<=0, win<=0, lose<=0, bulls<=0, cows<=0, go to ARMED.
  - A load that fails legality is silently ignored.
  - secret_load in ARMED or SCORE is ignored.
- Guess acceptance:
  - Only in ARMED, on the edge where guess_valid=1.
  - Illegal guess (guess_legal=0, or any nibble >9): guess_err=1 for the following cycle. State, attempts and score are unchanged.
  - Legal guess: latch it, clear the scratch counters, go to SCORE with index 0.
  - guess_valid in any state other than ARMED is ignored. There is no buffering and no guess_err.
- If secret_load and guess_valid arrive on the same edge, the secret rule applies. The guess is ignored because the state is not ARMED.
- SCORE runs one digit per cycle, index i = 0..3. Call the edge that accepts the guess E; the compares happen on edges E+1..E+4.
  - Bull: g[i]==s[i] adds 1 to bulls.
  - Cow: g[i]!=s[i] and g[i]==s[j] for some j!=i adds 1 to cows.
  - Each guess digit contributes at most 1. A repeated guess digit is scored independently.
- Completion at edge E+4:
  - bulls/cows outputs take the final counts and result_valid pulses for one cycle.
  - attempts increments and saturates at MAX_ATTEMPTS.
  - Next state: WIN if bulls==4 (win<=1). Else LOSE if the new attempts==MAX_ATTEMPTS (lose<=1). Else ARMED.
  - win takes priority over lose when both occur on the final attempt.
- busy=1 exactly in SCORE. armed=1 exactly in ARMED.
- bulls/cows hold their last values until the next completion or the next secret load.
- WIN and LOSE hold until reset or a legal secret load.

Optional Feature:
Macro: BULLS_COWS_DUP_CHECK_EN.
- Defined: a guess containing any repeated digit counts as illegal, giving guess_err, no attempt and no state change. A secret containing a repeated digit is ignored.
- Undefined: repeated digits are accepted and scored per the SCORE rule above.

Test Plan:
- Reset, then load secret 16'h1234 with secret_legal=1 -> next cycle armed=1, attempts=0, win=0, lose=0.
- Secret 1234, guess 16'h1243 -> busy high 4 cycles; result_valid pulse with bulls=2, cows=2, attempts=1; back to ARMED.
- Secret 1234, guess 16'h1234 -> bulls=4, cows=0, win=1, armed=0. A further guess_valid is ignored: no result_valid, no guess_err.
- Secret 1234, ten guesses of 16'h5678 -> each gives bulls=0, cows=0; after the 10th attempts=10 and lose=1. Then load 16'h9876 -> lose=0, attempts=0, armed=1.
- Guess 16'h12F4 or guess_legal=0 -> guess_err pulse, attempts unchanged. Also assert rst during the 2nd SCORE cycle -> all outputs 0 and state IDLE.
- Guess 16'h1123 against 1234:
  - Macro undefined -> bulls=1, cows=3.
  - Macro defined -> guess_err, attempts unchanged.
